// File: rtl/data_packer_16.sv
// Pairs a level-held byte-write stream into little-endian 16-bit words with byte
// enables and queues them in a first-word-fall-through FIFO for a valid/ready memory port.
module data_packer_16 #(
  parameter int unsigned ADDRESS_SIZE  = 14,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned FLUSH_TIMEOUT = 32
) (
  input  logic                    clk_memory,
  input  logic                    reset,
  input  logic                    write_en,
  input  logic [ADDRESS_SIZE:0]   write_addr,
  input  logic [7:0]              write_data,
  input  logic                    flush,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [15:0]             mem_data,
  output logic [1:0]              mem_byte_en,
  output logic                    overflow,
  output logic                    busy
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IDX_W   = PTR_W - 1;
  localparam int unsigned ENTRY_W = ADDRESS_SIZE + 18;
  localparam logic [7:0]  TIMEOUT = 8'(FLUSH_TIMEOUT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;

  logic [1:0]              state, state_nx;
  logic                    en_prev;
  logic [7:0]              pend_low, pend_low_nx;
  logic [ADDRESS_SIZE-1:0] pend_word, pend_word_nx;
  logic [7:0]              timer, timer_nx;
  logic [7:0]              carry_data, carry_data_nx;
  logic [ADDRESS_SIZE-1:0] carry_word, carry_word_nx;

  logic                    event_c;
  logic                    ev_odd;
  logic [ADDRESS_SIZE-1:0] ev_word;
  logic                    push;
  logic [ENTRY_W-1:0]      push_entry;

  logic [ENTRY_W-1:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic                    empty, full, pop, wr_accept;
  logic [ENTRY_W-1:0]      head;

  assign event_c = write_en & ~en_prev;
  assign ev_odd  = write_addr[0];
  assign ev_word = write_addr[ADDRESS_SIZE:1];

  // Pairing state machine: decides what (if anything) is pushed this cycle.
  always_comb begin
    state_nx      = state;
    pend_low_nx   = pend_low;
    pend_word_nx  = pend_word;
    timer_nx      = timer;
    carry_data_nx = carry_data;
    carry_word_nx = carry_word;
    push          = 1'b0;
    push_entry    = '0;
    case (state)
      IDLE: begin
        if (event_c) begin
          if (!ev_odd) begin
            pend_low_nx  = write_data;
            pend_word_nx = ev_word;
            timer_nx     = TIMEOUT;
            state_nx     = HOLD;
          end else begin
            push       = 1'b1;
            push_entry = {ev_word, write_data, 8'h00, 2'b10};
          end
        end
      end
      HOLD: begin
        if (event_c) begin
          if (ev_odd && (ev_word == pend_word)) begin
            push       = 1'b1;
            push_entry = {pend_word, write_data, pend_low, 2'b11};
            state_nx   = IDLE;
          end else begin
            push       = 1'b1;
            push_entry = {pend_word, 8'h00, pend_low, 2'b01};
            if (!ev_odd) begin
              pend_low_nx  = write_data;
              pend_word_nx = ev_word;
              timer_nx     = TIMEOUT;
            end else begin
              carry_data_nx = write_data;
              carry_word_nx = ev_word;
              state_nx      = EMIT;
            end
          end
        end else if (flush || (timer == 8'd1)) begin
          push       = 1'b1;
          push_entry = {pend_word, 8'h00, pend_low, 2'b01};
          state_nx   = IDLE;
        end else begin
          timer_nx = timer - 8'd1;
        end
      end
      EMIT: begin
        push       = 1'b1;
        push_entry = {carry_word, carry_data, 8'h00, 2'b10};
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_memory) begin
    if (reset) begin
      state      <= IDLE;
      en_prev    <= 1'b1;
      pend_low   <= '0;
      pend_word  <= '0;
      timer      <= '0;
      carry_data <= '0;
      carry_word <= '0;
    end else begin
      state      <= state_nx;
      en_prev    <= write_en;
      pend_low   <= pend_low_nx;
      pend_word  <= pend_word_nx;
      timer      <= timer_nx;
      carry_data <= carry_data_nx;
      carry_word <= carry_word_nx;
    end
  end

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign pop       = ~empty & mem_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_accept = push & (~full | pop);

  always_ff @(posedge clk_memory) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)       rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_memory) begin
    if (wr_accept) fifo_mem[wr_ptr[IDX_W-1:0]] <= push_entry;
  end

  assign head        = fifo_mem[rd_ptr[IDX_W-1:0]];
  assign mem_valid   = ~empty;
  assign mem_addr    = empty ? '0 : head[ENTRY_W-1:18];
  assign mem_data    = empty ? '0 : head[17:2];
  assign mem_byte_en = empty ? '0 : head[1:0];
  assign busy        = (state != IDLE) | ~empty;

endmodule

// File: tb/tb_data_packer_16.sv
// Directed bench for data_packer_16: expected words go into a queue as bytes are
// driven; a negedge monitor pops and compares each word the memory port accepts.
module tb_data_packer_16;

  localparam int unsigned AS = 14;
  localparam int unsigned T  = 32;

  logic          clk_memory = 1'b0;
  logic          reset;
  logic          write_en;
  logic [AS:0]   write_addr;
  logic [7:0]    write_data;
  logic          flush;
  logic          mem_valid;
  logic          mem_ready;
  logic [AS-1:0] mem_addr;
  logic [15:0]   mem_data;
  logic [1:0]    mem_byte_en;
  logic          overflow;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] sb [$];

  data_packer_16 #(.ADDRESS_SIZE(AS), .FIFO_DEPTH(4), .FLUSH_TIMEOUT(T)) dut (
    .clk_memory (clk_memory),
    .reset      (reset),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .flush      (flush),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_byte_en(mem_byte_en),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk_memory = ~clk_memory;

  function automatic logic [31:0] mk(input logic [AS-1:0] a, input logic [15:0] d,
                                     input logic [1:0] be);
    return {a, d, be};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every accepted word must be the next expected one.
  always @(negedge clk_memory) begin
    if (!reset && mem_valid && mem_ready) begin
      check("unexpected_word", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) check("word", {mem_addr, mem_data, mem_byte_en}, sb.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_memory); #1; end
  endtask

  task automatic start_byte(input logic [AS:0] a, input logic [7:0] d);
    write_addr = a;
    write_data = d;
    write_en   = 1'b1;
    @(posedge clk_memory); #1;
  endtask

  task automatic end_byte();
    idle(2);
    write_en = 1'b0;
    idle(1);
  endtask

  task automatic wr_byte(input logic [AS:0] a, input logic [7:0] d);
    start_byte(a, d);
    end_byte();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || mem_valid) && n < 60) begin
      @(negedge clk_memory);
      n++;
    end
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check({tag, "_valid"}, 32'(mem_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    @(posedge clk_memory); #1;
  endtask

  initial begin
    reset = 1'b1; write_en = 1'b0; write_addr = '0; write_data = '0;
    flush = 1'b0; mem_ready = 1'b1;
    repeat (3) @(posedge clk_memory);
    @(negedge clk_memory);
    check("rst_valid", 32'(mem_valid), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(mem_data), 32'd0);
    check("rst_be", 32'(mem_byte_en), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk_memory); #1;
    reset = 1'b0;
    idle(2);

    // Even/odd pair six cycles apart
    wr_byte(15'h0010, 8'hAA);
    idle(2);
    sb.push_back(mk(14'h0008, 16'h55AA, 2'b11));
    wr_byte(15'h0011, 8'h55);
    drain("pair");

    // Lone odd byte appears the cycle after the event edge
    sb.push_back(mk(14'h0010, 16'h7E00, 2'b10));
    @(negedge clk_memory);
    check("odd_pre_valid", 32'(mem_valid), 32'd0);
    @(posedge clk_memory); #1;
    start_byte(15'h0021, 8'h7E);
    @(negedge clk_memory);
    check("odd_valid", 32'(mem_valid), 32'd1);
    check("odd_head", {mem_addr, mem_data, mem_byte_en}, mk(14'h0010, 16'h7E00, 2'b10));
    end_byte();
    drain("odd");

    // Lone even byte times out exactly T cycles after its event
    sb.push_back(mk(14'h0018, 16'h0011, 2'b01));
    start_byte(15'h0030, 8'h11);
    idle(2);
    write_en = 1'b0;
    idle(T - 4);
    @(posedge clk_memory);
    @(negedge clk_memory);
    check("tmo_early_valid", 32'(mem_valid), 32'd0);
    check("tmo_busy", 32'(busy), 32'd1);
    @(posedge clk_memory);
    @(negedge clk_memory);
    check("tmo_valid", 32'(mem_valid), 32'd1);
    check("tmo_head", {mem_addr, mem_data, mem_byte_en}, mk(14'h0018, 16'h0011, 2'b01));
    @(posedge clk_memory); #1;
    drain("tmo");

    // Pending even byte displaced by an odd byte of another word
    wr_byte(15'h0040, 8'h01);
    idle(1);
    sb.push_back(mk(14'h0020, 16'h0001, 2'b01));
    sb.push_back(mk(14'h0021, 16'h0200, 2'b10));
    start_byte(15'h0043, 8'h02);
    @(negedge clk_memory);
    check("mis_first", {mem_addr, mem_data, mem_byte_en}, mk(14'h0020, 16'h0001, 2'b01));
    @(negedge clk_memory);
    check("mis_second", {mem_addr, mem_data, mem_byte_en}, mk(14'h0021, 16'h0200, 2'b10));
    idle(1);
    write_en = 1'b0;
    idle(1);
    drain("mis");

    // Backpressure: four words held, fifth dropped with sticky overflow
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) sb.push_back(mk(14'h0080 + 14'(i), {8'hB1 + 8'(i), 8'h00}, 2'b10));
      wr_byte(15'h0101 + 15'(2 * i), 8'hB1 + 8'(i));
      if (i == 3) begin
        @(negedge clk_memory);
        check("bp_overflow_before", 32'(overflow), 32'd0);
        check("bp_head4", {mem_addr, mem_data, mem_byte_en}, mk(14'h0080, 16'hB100, 2'b10));
        @(posedge clk_memory); #1;
      end
    end
    @(negedge clk_memory);
    check("bp_overflow", 32'(overflow), 32'd1);
    check("bp_valid", 32'(mem_valid), 32'd1);
    check("bp_head5", {mem_addr, mem_data, mem_byte_en}, mk(14'h0080, 16'hB100, 2'b10));
    @(posedge clk_memory); #1;
    mem_ready = 1'b1;
    drain("bp");
    check("bp_overflow_sticky", 32'(overflow), 32'd1);

    // Level-held strobe yields a single event
    sb.push_back(mk(14'h0100, 16'h3300, 2'b10));
    write_addr = 15'h0201; write_data = 8'h33; write_en = 1'b1;
    idle(10);
    write_en = 1'b0;
    idle(2);
    drain("level");

    // Flush in HOLD pushes the low byte immediately
    wr_byte(15'h0300, 8'h44);
    sb.push_back(mk(14'h0180, 16'h0044, 2'b01));
    flush = 1'b1;
    @(posedge clk_memory); #1;
    flush = 1'b0;
    @(negedge clk_memory);
    check("flush_head", {mem_addr, mem_data, mem_byte_en}, mk(14'h0180, 16'h0044, 2'b01));
    @(posedge clk_memory); #1;
    drain("flush");

    // Flush coincident with the pairing event is absorbed
    wr_byte(15'h0400, 8'h10);
    sb.push_back(mk(14'h0200, 16'h2010, 2'b11));
    flush = 1'b1;
    start_byte(15'h0401, 8'h20);
    flush = 1'b0;
    @(negedge clk_memory);
    check("coinc_head", {mem_addr, mem_data, mem_byte_en}, mk(14'h0200, 16'h2010, 2'b11));
    end_byte();
    drain("coinc");

    // Reset with a queued word, a pending byte and write_en still high
    mem_ready = 1'b0;
    wr_byte(15'h0601, 8'h77);
    start_byte(15'h0500, 8'h66);
    idle(1);
    reset = 1'b1;
    @(posedge clk_memory);
    @(negedge clk_memory);
    check("mrst_valid", 32'(mem_valid), 32'd0);
    check("mrst_fields", {mem_addr, mem_data, mem_byte_en}, 32'd0);
    check("mrst_overflow", 32'(overflow), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    @(posedge clk_memory); #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    idle(3);
    @(negedge clk_memory);
    check("post_rst_busy", 32'(busy), 32'd0);
    @(posedge clk_memory); #1;
    write_en = 1'b0;
    idle(T + 8);
    @(negedge clk_memory);
    check("post_rst_valid", 32'(mem_valid), 32'd0);
    check("post_rst_busy2", 32'(busy), 32'd0);
    check("post_rst_sb", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_packer_16.md
Name: data_packer_16

Overview:
- Downstream neighbour of the APF byte loader, in the clk_memory domain.
- Consumes the loader's synchronized byte-write stream (write_en held high for several cycles per byte, plus byte address and data).
- Pairs bytes into little-endian 16-bit words with byte enables and queues them in a small FIFO.
- Presents the words to a 16-bit memory controller over a valid/ready handshake.

Parameters:
- ADDRESS_SIZE, 14: byte address is ADDRESS_SIZE+1 bits; word address is ADDRESS_SIZE bits.
- FIFO_DEPTH, 4: output queue entries; must be a power of 2, at least 2.
- FLUSH_TIMEOUT, 32: idle cycles, 1..255, before a lone even byte is emitted alone.

Ports:
- clk_memory  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- write_en  in  1  byte strobe from the loader, level-held for several cycles per byte.
- write_addr  in  ADDRESS_SIZE+1  byte address.
- write_data  in  8  byte value.
- flush  in  1  single-cycle pulse: emit any pending byte now.
- mem_valid  out  1  FIFO head is valid.
- mem_ready  in  1  controller accepts the head this cycle.
- mem_addr  out  ADDRESS_SIZE  word address, equal to write_addr[ADDRESS_SIZE:1].
- mem_data  out  16  word; the even byte is in [7:0], the odd byte in [15:8].
- mem_byte_en  out  2  bit0 = low byte valid, bit1 = high byte valid.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- busy  out  1  a byte is pending, or the FIFO is not empty.

Behaviour:
- Clock and reset: one clock (clk_memory); reset is synchronous and active-high.
- Reset values: state IDLE, FIFO empty, mem_valid=0, mem_addr=0, mem_data=0, mem_byte_en=0, overflow=0, busy=0, timer=0.
- Edge detect: en_prev is a register that resets to 1, so a write_en already high at reset release is ignored.
  - event = write_en & ~en_prev.
  - write_addr and write_data are sampled in the event cycle.
- Inter-event spacing: events at least 2 cycles apart are guaranteed by the loader. Closer spacing is unsupported.
- State IDLE:
  - Event with addr[0]=0: latch the byte into the low byte of the pending register, latch the word address, load timer=FLUSH_TIMEOUT, go to HOLD.
  - Event with addr[0]=1: push {addr, {byte,8'h00}, 2'b10} this cycle, stay in IDLE.
  - flush in IDLE has no effect.
- State HOLD:
  - Event with addr[0]=1 and the same word address: push {word, {byte,low}, 2'b11}, go to IDLE.
  - Event with any other address: push pending {word, {8'h00,low}, 2'b01}. Then:
    - new byte even: it becomes the new pending byte, timer reloads, stay in HOLD.
    - new byte odd: capture it in a carry register, go to EMIT; EMIT pushes it with mask 2'b10 on the next cycle and returns to IDLE.
  - No event, with flush=1 or timer==1: push pending with mask 01, go to IDLE.
  - Otherwise decrement the timer.
  - An event in the same cycle as flush or timer expiry takes precedence; the flush is absorbed.
- FIFO:
  - First-word fall-through; mem_* outputs reflect the head combinationally from registered storage.
  - mem_valid = !empty.
  - Pop when mem_valid & mem_ready.
  - Head fields stay stable while mem_valid & !mem_ready.
  - Push and pop in the same cycle are allowed in every fill state, including full.
- Overflow: a push while full with no simultaneous pop drops the new word and sets overflow=1 until reset. The pending/state update still proceeds.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full means MSBs differ and LSBs are equal.
- Latency: a push at edge k gives mem_valid=1 with that word at the head in the cycle after edge k. From the cycle write_en first reads high to mem_valid is 1 cycle for a completing odd byte.
- busy = (state != IDLE) | !empty.
- Reset mid-operation: the pending byte, the carry register and FIFO contents are discarded, with no emission.

Test Plan:
- Pair: write_en pulses at addr 0x0010 data 0xAA, then 6 cycles later at 0x0011 data 0x55, mem_ready=1 → exactly one word, addr 0x0008, data 0x55AA, byte_en 2'b11.
- Lone odd and timeout: byte 0x0021=0x7E from IDLE → next cycle word 0x0010 / 0x7E00 / 2'b10. Byte 0x0030=0x11 with no follow-up → exactly FLUSH_TIMEOUT cycles later, word 0x0018 / 0x0011 / 2'b01.
- Mismatch plus odd: pending 0x0040=0x01, then 0x0043=0x02 → two consecutive pushes: 0x0020/0x0001/01, then 0x0021/0x0200/10.
- Backpressure and overflow (FIFO_DEPTH=4): mem_ready=0, 5 odd bytes → 4 entries held stable, overflow=1. Release mem_ready → exactly 4 words pop in order, then mem_valid=0 and busy=0.
- Edge and flush: hold write_en high for 10 cycles → one event only. flush pulse in HOLD → immediate mask-01 push. flush coincident with an odd pairing event → single 2'b11 word.
- Reset: assert reset while write_en is high and a byte is pending → all outputs 0, no word is emitted after release, and the still-high write_en is not counted as a new event.
